adder_sequencer: RTL and testbench
==================================

Name: adder_sequencer

Overview:
- Upstream control stage for the signed 4-bit hex display decoder.
- Debounces a raw push-button and latches two signed 4-bit operands from slide switches, one per press.
- Computes their registered two's-complement sum and flags signed overflow.
- Drives a 4-bit value bus straight into the decoder's nibble input, so the display shows live operand entry and then the result.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a changed synchronized button level must persist before it is accepted (10 ms at 50 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  4  raw signed operand switches, asynchronous to clk.
- btn_n  input  1  raw push-button, active-low (0 = pressed), bouncing, asynchronous.
- val  output  4  signed nibble for the display decoder.
- ovf  output  1  signed overflow of the displayed result.
- stage  output  2  current FSM state: 00 = entering A, 01 = entering B, 10 = showing sum.

Behaviour:
- Reset: one clock, clk. Reset rst_n is asynchronous active-low; all flops clear immediately on assertion.
  - Sync flops and debounced level reset to 1 (released). Debounce counter resets to 0.
  - a_q, b_q and sum_q reset to 0. val = 0000, ovf = 0, stage = 00.
- Input synchronization: btn_n and sw each pass through a 2-FF synchronizer; sw reset value is 0000.
- Debounce:
  - Counter clears whenever the synchronized button equals the debounced level.
  - Otherwise the counter increments each cycle; when it reaches DEBOUNCE_CYCLES-1, the debounced level takes the new value and the counter clears.
  - press is a 1-cycle internal pulse on a debounced 1->0 transition only.
  - Holding the button yields exactly one press; release generates none.
- FSM (state encoding equals stage):
  - S_A (00): val <= synced sw every cycle. On press: a_q <= synced sw, go to S_B.
  - S_B (01): val <= synced sw every cycle. On press: b_q <= synced sw; sum_q <= a_q + synced sw (4-bit, wraps); ovf <= (a_q[3] == sw[3]) && (result[3] != a_q[3]); go to S_SUM.
  - S_SUM (10): val <= sum_q; ovf held. On press: ovf <= 0, go to S_A.
  - Encoding 11 is unreachable; if entered, go to S_A next cycle with val = 0000 and ovf = 0.
- Timing and latency:
  - val, ovf and stage are registered outputs.
  - Switch change to val takes 3 cycles (2 sync stages plus output register).
  - Press pulse to new stage takes 1 cycle; the val/ovf update for the sum appears on the cycle after the state change.
- Arithmetic: pure two's complement; wrap-around is the intended result and ovf is the only indication (7+1 shows -8 with ovf = 1).
- Switch changes in S_SUM have no effect on val.
- Reset mid-debounce or mid-sequence abandons everything; after release the block is in S_A with no pending press.

Optional Feature:
- Macro: ADDER_SEQUENCER_SUBTRACT_EN.
- Defined:
  - Adds port op_sub (input, 1), passed through its own 2-FF synchronizer.
  - The synchronized op_sub is sampled on the S_B press. When 1: result = a_q - sw and ovf = (a_q[3] != sw[3]) && (result[3] != a_q[3]). When 0: addition as above.
  - Adds 1 flop holding the latched op so S_SUM stays stable.
- Undefined: op_sub port and its logic are absent; always adds.

Test Plan (bench DEBOUNCE_CYCLES = 4):
- Reset: assert rst_n low mid-clock -> val = 0000, ovf = 0, stage = 00 immediately, held through deassertion.
- Bounce: btn_n low for 3 cycles then high, repeated 5 times -> stage stays 00. Hold low 20 cycles -> exactly one transition to 01.
- Add: sw = 0011, press; sw = 0010, press -> stage 10, val = 0101, ovf = 0. Toggle sw afterwards -> val unchanged.
- Overflow and wrap:
  - 0111 + 0001 -> val = 1000, ovf = 1; next press -> stage 00, ovf = 0.
  - 1000 + 1111 -> val = 0111, ovf = 1.
- Reset mid-sequence: in S_B with a_q = 0101, assert rst_n -> stage 00, val = 0000. The next two presses with 0001 and 0001 give val = 0010.
- ADDER_SEQUENCER_SUBTRACT_EN:
  - op_sub = 1: 0010 - 0101 -> val = 1101, ovf = 0.
  - 1000 - 0001 -> val = 0111, ovf = 1.
  - op_sub toggled in S_SUM -> val unchanged.

Source files
------------

// File: rtl/adder_sequencer.sv
// Debounced two-operand signed nibble adder feeding the hex display decoder.
// Define ADDER_SEQUENCER_SUBTRACT_EN to add the op_sub input (a - b on request).
module adder_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_n,
`ifdef ADDER_SEQUENCER_SUBTRACT_EN
  input  logic       op_sub,
`endif
  output logic [3:0] val,
  output logic       ovf,
  output logic [1:0] stage
);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_SUM = 2'b10,
    S_BAD = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sw_s1_q, sw_s2_q;
  logic             btn_s1_q, btn_s2_q;
  logic             btn_db_q, btn_db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;
  state_e           state_q, state_d;
  logic [3:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [3:0]       val_q, val_d;
  logic             ovf_q, ovf_d;
  logic             sum_ovf;
`ifdef ADDER_SEQUENCER_SUBTRACT_EN
  logic             op_s1_q, op_s2_q;
  logic             op_q, op_d;
`endif

  // Debounce: the button level must disagree with the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles before it is taken.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d    = cnt_q;
    btn_db_d = btn_db_q;
    press    = 1'b0;
    if (btn_s2_q == btn_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      btn_db_d = btn_s2_q;
      cnt_d    = '0;
      press    = ~btn_s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Overflow of the stored result, derived from the latched operands.
`ifdef ADDER_SEQUENCER_SUBTRACT_EN
  assign sum_ovf = op_q ? ((a_q[3] != b_q[3]) && (sum_q[3] != a_q[3]))
                        : ((a_q[3] == b_q[3]) && (sum_q[3] != a_q[3]));
`else
  assign sum_ovf = (a_q[3] == b_q[3]) && (sum_q[3] != a_q[3]);
`endif

  // Next-state and operand capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
`ifdef ADDER_SEQUENCER_SUBTRACT_EN
    op_d    = op_q;
`endif
    unique case (state_q)
      S_A: if (press) begin
        a_d     = sw_s2_q;
        state_d = S_B;
      end
      S_B: if (press) begin
        b_d     = sw_s2_q;
`ifdef ADDER_SEQUENCER_SUBTRACT_EN
        op_d    = op_s2_q;
        sum_d   = op_s2_q ? (a_q - sw_s2_q) : (a_q + sw_s2_q);
`else
        sum_d   = a_q + sw_s2_q;
`endif
        state_d = S_SUM;
      end
      S_SUM: if (press) state_d = S_A;
      default: state_d = S_A;
    endcase
  end

  // Registered output values.
  always_comb begin
    val_d = 4'h0;
    ovf_d = 1'b0;
    unique case (state_q)
      S_A, S_B: val_d = sw_s2_q;
      S_SUM: begin
        val_d = sum_q;
        ovf_d = press ? 1'b0 : sum_ovf;
      end
      default: begin
        val_d = 4'h0;
        ovf_d = 1'b0;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q  <= 4'h0;
      sw_s2_q  <= 4'h0;
      btn_s1_q <= 1'b1;
      btn_s2_q <= 1'b1;
      btn_db_q <= 1'b1;
      cnt_q    <= '0;
      state_q  <= S_A;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      sum_q    <= 4'h0;
      val_q    <= 4'h0;
      ovf_q    <= 1'b0;
`ifdef ADDER_SEQUENCER_SUBTRACT_EN
      op_s1_q  <= 1'b0;
      op_s2_q  <= 1'b0;
      op_q     <= 1'b0;
`endif
    end else begin
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= btn_n;
      btn_s2_q <= btn_s1_q;
      btn_db_q <= btn_db_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      val_q    <= val_d;
      ovf_q    <= ovf_d;
`ifdef ADDER_SEQUENCER_SUBTRACT_EN
      op_s1_q  <= op_sub;
      op_s2_q  <= op_s1_q;
      op_q     <= op_d;
`endif
    end
  end

  assign val   = val_q;
  assign ovf   = ovf_q;
  assign stage = state_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Self-checking bench for adder_sequencer: cycle-level behavioural model plus
// directed literal checks and randomized press/bounce/switch stimulus.
module tb_adder_sequencer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn_n;
  logic       op_sub;
  logic [3:0] val;
  logic       ovf;
  logic [1:0] stage;

  int n_checks = 0;
  int n_fail   = 0;

  adder_sequencer #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .btn_n (btn_n),
`ifdef ADDER_SEQUENCER_SUBTRACT_EN
    .op_sub(op_sub),
`endif
    .val   (val),
    .ovf   (ovf),
    .stage (stage)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw input history, accepted button level, and the
  // operand/result bookkeeping expressed with plain integer arithmetic.
  logic       btn_h[$];
  logic [3:0] sw_h[$];
  logic       op_h[$];
  logic       m_db;
  int         m_stage;
  logic [3:0] m_a, m_sum, m_val;
  logic       m_ovf, m_flag;

  function automatic void model_reset();
    btn_h.delete(); sw_h.delete(); op_h.delete();
    for (int i = 0; i < D + 2; i++) begin
      btn_h.push_back(1'b1);
      sw_h.push_back(4'h0);
      op_h.push_back(1'b0);
    end
    m_db = 1'b1; m_stage = 0;
    m_a = 4'h0; m_sum = 4'h0; m_val = 4'h0;
    m_ovf = 1'b0; m_flag = 1'b0;
  endfunction

  function automatic void model_step(input logic b_raw, input logic [3:0] s_raw, input logic o_raw);
    logic [3:0] s_sw;
    logic       s_op;
    logic       press;
    bit         run;
    int         sa, sb, r;
    btn_h.push_back(b_raw); sw_h.push_back(s_raw); op_h.push_back(o_raw);
    if (btn_h.size() > D + 2) begin
      void'(btn_h.pop_front()); void'(sw_h.pop_front()); void'(op_h.pop_front());
    end
    // Synchronized values seen by the DUT before this edge lag the raw pins by two edges.
    s_sw = sw_h[$-2];
    s_op = op_h[$-2];
    run = 1'b1;
    for (int k = 2; k <= D + 1; k++) if (btn_h[$-k] == m_db) run = 1'b0;
    press = run && m_db;
    if (run) m_db = ~m_db;
`ifndef ADDER_SEQUENCER_SUBTRACT_EN
    s_op = 1'b0;
`endif
    case (m_stage)
      0: begin
        m_val = s_sw; m_ovf = 1'b0;
        if (press) begin m_a = s_sw; m_stage = 1; end
      end
      1: begin
        m_val = s_sw; m_ovf = 1'b0;
        if (press) begin
          sa = $signed(m_a); sb = $signed(s_sw);
          r  = s_op ? (sa - sb) : (sa + sb);
          m_sum  = r[3:0];
          m_flag = (r > 7) || (r < -8);
          m_stage = 2;
        end
      end
      default: begin
        m_val = m_sum;
        m_ovf = press ? 1'b0 : m_flag;
        if (press) m_stage = 0;
      end
    endcase
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(btn_n, sw, op_sub);
    end
  end

  always @(negedge clk) begin
    check("val_vs_model", {4'h0, val}, {4'h0, m_val});
    check("ovf_vs_model", {7'h0, ovf}, {7'h0, m_ovf});
    check("stage_vs_model", {6'h0, stage}, 8'(m_stage));
  end

  task automatic press(input logic [3:0] v, input logic op);
    @(negedge clk);
    sw = v; op_sub = op;
    repeat (3) @(negedge clk);
    btn_n = 1'b0;
    repeat (D + 6) @(negedge clk);
    btn_n = 1'b1;
    repeat (D + 6) @(negedge clk);
  endtask

  task automatic bounce(input int low_cycles, input int high_cycles);
    btn_n = 1'b0;
    repeat (low_cycles) @(negedge clk);
    btn_n = 1'b1;
    repeat (high_cycles) @(negedge clk);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_val_immediate", {4'h0, val}, 8'h00);
    check("rst_ovf_immediate", {7'h0, ovf}, 8'h00);
    check("rst_stage_immediate", {6'h0, stage}, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_stage_held", {6'h0, stage}, 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sw = 4'h0; btn_n = 1'b1; op_sub = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_val", {4'h0, val}, 8'h00);
    check("reset_stage", {6'h0, stage}, 8'h00);

    // Live operand entry, then an async reset in the middle of a cycle.
    sw = 4'h9;
    repeat (4) @(negedge clk);
    check("live_sw_val", {4'h0, val}, 8'h09);
    async_reset();

    // Bounces shorter than the debounce window are ignored.
    sw = 4'h3;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) bounce(3, 3);
    repeat (4) @(negedge clk);
    check("bounce_stage", {6'h0, stage}, 8'h00);
    bounce(20, 12);
    check("hold_one_press", {6'h0, stage}, 8'h01);

    press(4'h2, 1'b0);
    check("add_stage", {6'h0, stage}, 8'h02);
    check("add_val", {4'h0, val}, 8'h05);
    check("add_ovf", {7'h0, ovf}, 8'h00);
    check("model_add_val", {4'h0, m_val}, 8'h05);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sw = 4'($urandom_range(0, 15));
    end
    repeat (4) @(negedge clk);
    check("sum_ignores_sw", {4'h0, val}, 8'h05);

    press(4'h0, 1'b0);
    check("back_to_a", {6'h0, stage}, 8'h00);

    press(4'h7, 1'b0); press(4'h1, 1'b0);
    check("wrap_val", {4'h0, val}, 8'h08);
    check("wrap_ovf", {7'h0, ovf}, 8'h01);
    check("model_wrap_ovf", {7'h0, m_ovf}, 8'h01);
    press(4'h0, 1'b0);
    check("ovf_cleared_stage", {6'h0, stage}, 8'h00);
    check("ovf_cleared", {7'h0, ovf}, 8'h00);

    press(4'h8, 1'b0); press(4'hF, 1'b0);
    check("neg_wrap_val", {4'h0, val}, 8'h07);
    check("neg_wrap_ovf", {7'h0, ovf}, 8'h01);
    press(4'h0, 1'b0);

    press(4'h5, 1'b0);
    check("in_b", {6'h0, stage}, 8'h01);
    async_reset();
    check("post_rst_val", {4'h0, val}, 8'h00);
    press(4'h1, 1'b0); press(4'h1, 1'b0);
    check("post_rst_sum", {4'h0, val}, 8'h02);
    check("post_rst_ovf", {7'h0, ovf}, 8'h00);
    press(4'h0, 1'b0);

`ifdef ADDER_SEQUENCER_SUBTRACT_EN
    press(4'h2, 1'b1); press(4'h5, 1'b1);
    check("sub_val", {4'h0, val}, 8'h0D);
    check("sub_ovf", {7'h0, ovf}, 8'h00);
    press(4'h0, 1'b0);
    press(4'h8, 1'b1); press(4'h1, 1'b1);
    check("sub_wrap_val", {4'h0, val}, 8'h07);
    check("sub_wrap_ovf", {7'h0, ovf}, 8'h01);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      op_sub = ~op_sub;
    end
    repeat (4) @(negedge clk);
    check("sub_op_toggle_val", {4'h0, val}, 8'h07);
    check("sub_op_toggle_ovf", {7'h0, ovf}, 8'h01);
    press(4'h0, 1'b0);
`endif

    // Randomized presses, glitches and switch wiggles against the model.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0, 1: press(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        2:    bounce($urandom_range(1, D - 1), $urandom_range(3, 6));
        default: begin
          repeat ($urandom_range(1, 6)) begin
            @(negedge clk);
            sw = 4'($urandom_range(0, 15));
            op_sub = 1'($urandom_range(0, 1));
          end
        end
      endcase
    end
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
